// File: rtl/instr_encoder.sv
// Packs opcode, register fields and a signed immediate into an RV32I word (I/S/B/J),
// with one- or two-word LUI/ADDI expansion for load-immediate requests.
module instr_encoder #(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_li,
   input  logic [1:0]       immsrc,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [Width-1:0] imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [Width-1:0] out_instr,
   output logic             out_err
);

   localparam logic [6:0]  OpImm = 7'b0010011;
   localparam logic [6:0]  OpLui = 7'b0110111;
   localparam logic [31:0] Nop   = 32'h0000_0013;

   typedef enum logic [0:0] {StIdle, StLiSecond} state_e;

   state_e      state_q;
   logic [31:0] pend_q;

   logic        fits12, fits13, fits21;
   logic [19:0] hi20;
   logic [31:0] enc_word, enc_second;
   logic        enc_err, enc_two;
   logic        accept, advance;

   // Sign-extension checks: upper bits all equal means the value fits the signed field.
   assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
   assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
   assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

   // Rounds hi20 up when lo12 will be sign-extended negative by ADDI.
   assign hi20 = imm[31:12] + {19'd0, imm[11]};

   always_comb begin
      enc_word   = Nop;
      enc_err    = 1'b0;
      enc_two    = 1'b0;
      enc_second = {imm[11:0], rd, 3'b000, rd, OpImm};
      if (in_li) begin
         if (fits12) begin
            enc_word = {imm[11:0], 5'd0, 3'b000, rd, OpImm};
         end else begin
            enc_word = {hi20, rd, OpLui};
            enc_two  = (imm[11:0] != 12'd0);
         end
      end else begin
         unique case (immsrc)
            2'b00: begin
               if (fits12) enc_word = {imm[11:0], rs1, funct3, rd, opcode};
               else        enc_err  = 1'b1;
            end
            2'b01: begin
               if (fits12) enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
               else        enc_err  = 1'b1;
            end
            2'b10: begin
               if (fits13 && !imm[0]) begin
                  enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
               end else begin
                  enc_err = 1'b1;
               end
            end
            2'b11: begin
               if (fits21 && !imm[0]) enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
               else                   enc_err  = 1'b1;
            end
         endcase
      end
   end

   assign in_ready = (state_q == StIdle) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign advance  = (state_q == StLiSecond) && out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         pend_q    <= 32'd0;
         out_valid <= 1'b0;
         out_instr <= 32'd0;
         out_err   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_instr <= enc_word;
         out_err   <= enc_err;
         pend_q    <= enc_second;
         if (enc_two) state_q <= StLiSecond;
      end else if (advance) begin
         // LUI leaves and ADDI takes its place in the same cycle.
         out_instr <= pend_q;
         out_err   <= 1'b0;
         state_q   <= StIdle;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: scoreboard of expected words from an arithmetic
// model, immediate round-trip decode, and literal checks of the worked examples.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, in_li, out_valid, out_ready, out_err;
   logic [1:0]  immsrc;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm, out_instr;

   instr_encoder #(.Width(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_li(in_li),
      .immsrc(immsrc), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
      .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_err(out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          li;
      logic [1:0]  fmt;
      logic [31:0] imm;
      logic [31:0] instr;
      bit          err;
   } word_t;

   word_t       q[$];
   logic [31:0] log_instr[$];
   bit          log_err[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          rmode = 0;  // 0: out_ready=1, 1: random, 2: driven by main

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] immgen(logic [31:0] i, logic [1:0] fmt);
      case (fmt)
         2'b00:   return {{20{i[31]}}, i[31:20]};
         2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
         2'b10:   return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
         default: return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction

   function automatic void model(bit li, logic [1:0] fmt, logic [6:0] op, logic [2:0] f3,
                                 logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                                 logic [31:0] im);
      longint      v;
      logic [31:0] hi;
      bit          ok;
      word_t       w;
      v = longint'($signed(im));
      w.li = li; w.fmt = fmt; w.imm = im; w.err = 1'b0;
      if (li) begin
         hi = (im + 32'h800) >> 12;
         if (v >= -2048 && v <= 2047) begin
            w.instr = {im[11:0], 5'd0, 3'b000, d, 7'h13};
            q.push_back(w);
         end else begin
            w.instr = {hi[19:0], d, 7'h37};
            q.push_back(w);
            if (im[11:0] != 12'd0) begin
               w.instr = {im[11:0], d, 3'b000, d, 7'h13};
               q.push_back(w);
            end
         end
      end else begin
         case (fmt)
            2'b00, 2'b01: ok = (v >= -2048 && v <= 2047);
            2'b10:        ok = (v >= -4096 && v <= 4094 && im[0] == 1'b0);
            default:      ok = (v >= -1048576 && v <= 1048574 && im[0] == 1'b0);
         endcase
         if (!ok) begin
            w.instr = 32'h13;
            w.err   = 1'b1;
         end else begin
            case (fmt)
               2'b00:   w.instr = {im[11:0], s1, f3, d, op};
               2'b01:   w.instr = {im[11:5], s2, s1, f3, im[4:0], op};
               2'b10:   w.instr = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
               default: w.instr = {im[20], im[10:1], im[11], im[19:12], d, op};
            endcase
         end
         q.push_back(w);
      end
   endfunction

   // Scoreboard: every negedge, check handshake signals and the word on the output.
   initial begin
      logic exp_ready;
      forever begin
         @(negedge clk);
         if (reset) begin
            q.delete();
         end else begin
            exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0 && out_valid) begin
               chk("out_instr", out_instr, q[0].instr);
               chk("out_err", {31'd0, out_err}, {31'd0, q[0].err});
            end
            if (out_valid && out_ready && q.size() != 0) begin
               log_instr.push_back(out_instr);
               log_err.push_back(out_err);
               if (!q[0].li && !q[0].err) chk("roundtrip", immgen(out_instr, q[0].fmt), q[0].imm);
               void'(q.pop_front());
            end
            if (in_valid && in_ready)
               model(in_li, immsrc, opcode, funct3, rd, rs1, rs2, imm);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rmode == 0)      out_ready = 1'b1;
         else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic send(bit li, logic [1:0] fmt, logic [6:0] op, logic [2:0] f3, logic [4:0] d,
                       logic [4:0] s1, logic [4:0] s2, logic [31:0] im);
      in_li = li; immsrc = fmt; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
      in_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("accept_timeout", 32'd0, 32'd1);
   endtask

   logic [31:0] dir_exp[11];
   bit          dir_err[11];
   int          bounds[16];
   int          lsz;
   logic [31:0] rimm;

   initial begin
      dir_exp = '{32'hFFF30293, 32'h00208463, 32'hFFDFF0EF, 32'h12346537, 32'hFFF50513,
                  32'h00005537, 32'hFFB00513, 32'h00000013, 32'h00000013, 32'h00000013,
                  32'h0};
      dir_err = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
      bounds  = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098, 1048574, 1048575,
                  1048576, -1048576, -1048578, 0, -1};
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_li = 1'b0; immsrc = 2'b00; opcode = 7'd0; funct3 = 3'd0;
      rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_out_instr", out_instr, 32'd0);
      chk("reset_out_err", {31'd0, out_err}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Worked examples, back to back.
      send(0, 2'b00, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFFFFFF);
      send(0, 2'b10, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8);
      send(0, 2'b11, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC);
      send(1, 2'b00, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
      send(1, 2'b00, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'h00005000);
      send(1, 2'b00, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'hFFFFFFFB);
      send(0, 2'b00, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'd2048);
      send(0, 2'b10, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3);
      send(0, 2'b11, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00100000);
      repeat (4) @(posedge clk);
      #1;
      chk("directed_count", log_instr.size(), 32'd10);
      for (int i = 0; i < 10 && i < log_instr.size(); i++) begin
         chk($sformatf("directed_instr[%0d]", i), log_instr[i], dir_exp[i]);
         chk($sformatf("directed_err[%0d]", i), {31'd0, log_err[i]}, {31'd0, dir_err[i]});
      end

      // Two-word li under three cycles of backpressure.
      rmode = 2; out_ready = 1'b0;
      send(1, 2'b00, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_lui", out_instr, 32'h12346537);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("stall_count", log_instr.size(), 32'd12);
      if (log_instr.size() == 12) begin
         chk("stall_word0", log_instr[10], 32'h12346537);
         chk("stall_word1", log_instr[11], 32'hFFF50513);
      end

      // Reset while the ADDI word is still pending.
      out_ready = 1'b0;
      send(1, 2'b00, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_li_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_li_in_ready", {31'd0, in_ready}, 32'd1);
      lsz = log_instr.size();
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_li_no_addi", log_instr.size(), lsz);

      // Random requests with random backpressure.
      rmode = 1;
      for (int n = 0; n < 1000; n++) begin
         case ($urandom_range(0, 5))
            0:       rimm = $urandom;
            1:       rimm = 32'($urandom_range(0, 10000)) - 32'd5000;
            2:       rimm = bounds[$urandom_range(0, 15)];
            3:       rimm = 32'($urandom_range(0, 2400000)) - 32'd1200000;
            4:       rimm = (32'($urandom_range(0, 10000)) - 32'd5000) & ~32'd1;
            default: rimm = $urandom & 32'hFFFFF000;
         endcase
         send(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 7'($urandom),
              3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rimm);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end

      rmode = 0;
      for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
      chk("drain", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
